branch_predictor: RTL

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting between fetch and execute in the 5-stage pipeline. Fetch presents its PC each cycle and receives a same-cycle taken/not-taken prediction plus next PC. Execute returns the resolved outcome of each branch/jump one stage later, and the block trains its table from it. This is the consumer of execute's `is_branch_pype2` / `PC_pype2` / `branch_BTB_contral` / `branch_BTB_PC` / `branch_miss_contral` outputs and the producer of `is_branch_predict_pype1`.

---
 rtl/branch_predictor_if.sv | 28 ++
 rtl/branch_predictor.sv | 107 ++++++++++
 2 files changed

// File: rtl/branch_predictor_if.sv
// Fetch/execute <-> branch predictor bundle.
// master: pipeline side (drives fetch PC and resolved-branch training).
// slave : predictor side (returns prediction and perf counters).
interface branch_predictor_if;
  logic [31:0] fetch_PC;
  logic        predict_taken;
  logic [31:0] predict_PC;
  logic        update_valid;
  logic        update_hold;
  logic [31:0] update_PC;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_miss;
  logic [31:0] bp_branch_count;
  logic [31:0] bp_miss_count;

  modport master (
    output fetch_PC, update_valid, update_hold, update_PC,
           update_taken, update_target, update_miss,
    input  predict_taken, predict_PC, bp_branch_count, bp_miss_count
  );

  modport slave (
    input  fetch_PC, update_valid, update_hold, update_PC,
           update_taken, update_target, update_miss,
    output predict_taken, predict_PC, bp_branch_count, bp_miss_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Lookup is combinational from fetch_PC; training comes from execute one
// stage later and is written on the clock edge where it is accepted.
// Optional feature macro: BP_PERF_CNT_EN enables the accepted-update and
// misprediction counters; without it both counter outputs read zero.
module branch_predictor #(
  parameter int INDEX_W = 4
) (
  input logic              clk,
  input logic              rst,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_W;
  localparam int TAG_W   = 30 - INDEX_W;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [INDEX_W-1:0] fetch_idx;
  logic [TAG_W-1:0]   fetch_tag;
  logic               fetch_hit;
  logic [INDEX_W-1:0] upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  logic               upd_hit;
  logic               upd_accept;
  logic [1:0]         ctr_d;

  assign fetch_idx = bp.fetch_PC[INDEX_W+1:2];
  assign fetch_tag = bp.fetch_PC[31:INDEX_W+2];
  assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

  assign bp.predict_taken = fetch_hit & ctr_q[fetch_idx][1];
  assign bp.predict_PC    = bp.predict_taken ? target_q[fetch_idx]
                                             : bp.fetch_PC + 32'd4;

  assign upd_idx = bp.update_PC[INDEX_W+1:2];
  assign upd_tag = bp.update_PC[31:INDEX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // A taken branch with a misaligned target is execute's exception path,
  // so it never trains; a held execute stage re-presents the same branch.
  assign upd_accept = bp.update_valid && !bp.update_hold &&
                      (!bp.update_taken || (bp.update_target[1:0] == 2'b00));

  // Saturating step of the direction counter for the entry being trained.
  always_comb begin
    ctr_d = ctr_q[upd_idx];
    if (bp.update_taken) begin
      if (ctr_q[upd_idx] != 2'b11) ctr_d = ctr_q[upd_idx] + 2'd1;
    end else begin
      if (ctr_q[upd_idx] != 2'b00) ctr_d = ctr_q[upd_idx] - 2'd1;
    end
  end

  // Table write: train on hit, allocate on taken miss, clear on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (upd_accept) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_d;
        if (bp.update_taken) target_q[upd_idx] <= bp.update_target;
      end else if (bp.update_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= bp.update_target;
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        unused_perf;

  assign branch_cnt_d = branch_cnt_q + 32'd1;
  assign miss_cnt_d   = miss_cnt_q + 32'd1;

  // Perf counters count only updates that actually trained the table path.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q <= 32'd0;
      miss_cnt_q   <= 32'd0;
    end else if (upd_accept) begin
      branch_cnt_q <= branch_cnt_d;
      if (bp.update_miss) miss_cnt_q <= miss_cnt_d;
    end
  end

  assign bp.bp_branch_count = branch_cnt_q;
  assign bp.bp_miss_count   = miss_cnt_q;
  assign unused_perf = ^{bp.fetch_PC[1:0], bp.update_PC[1:0]};
`else
  logic unused_perf;

  assign bp.bp_branch_count = 32'd0;
  assign bp.bp_miss_count   = 32'd0;
  assign unused_perf = ^{bp.fetch_PC[1:0], bp.update_PC[1:0], bp.update_miss};
`endif

endmodule
